// File: rtl/core_bus_master.sv
// Single-outstanding initiator for the core bus. It takes one read or write request
// and runs one cyc/stb cycle. An ack-timeout watchdog turns a missing ack into an error response.
module core_bus_master #(
    parameter int BUS_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [BUS_WIDTH-1:0]  req_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BUS_WIDTH-1:0]  rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  core_cyc_o,
    output logic                  core_stb_o,
    output logic                  core_we_o,
    output logic [ADDR_WIDTH-1:0] core_addr_o,
    output logic [BUS_WIDTH-1:0]  core_data_o,
    input  logic [BUS_WIDTH-1:0]  core_data_i,
    input  logic                  core_ack_i
);
    // A 1-bit counter is kept when the watchdog is disabled so the width is never zero.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0]  data_q, data_d;
    logic [BUS_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    data_d  = req_data_i;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ack takes priority over a timeout expiring on the same edge.
                if (core_ack_i) begin
                    rsp_data_d = we_q ? '0 : core_data_i;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (timeout_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else if (TIMEOUT_CYCLES > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign core_cyc_o  = (state_q == BUS);
    assign core_stb_o  = (state_q == BUS);
    assign rsp_valid_o = (state_q == RESP);
    assign core_we_o   = we_q;
    assign core_addr_o = addr_q;
    assign core_data_o = data_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_core_bus_master.sv
// Scoreboard bench for core_bus_master with an 8-cycle ack timeout.
module tb_core_bus_master;
    localparam int BW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid_i, req_ready_o, req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [BW-1:0] req_data_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [BW-1:0] rsp_data_o;
    logic          core_cyc_o, core_stb_o, core_we_o, core_ack_i;
    logic [AW-1:0] core_addr_o;
    logic [BW-1:0] core_data_o, core_data_i;

    typedef struct {
        logic [BW-1:0] data;
        logic          err;
    } rsp_t;
    rsp_t exp_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    core_bus_master #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .core_cyc_o(core_cyc_o), .core_stb_o(core_stb_o), .core_we_o(core_we_o),
        .core_addr_o(core_addr_o), .core_data_o(core_data_o),
        .core_data_i(core_data_i), .core_ack_i(core_ack_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ack_delay < 0 means never ack. hold = cycles rsp_ready stays low, stray = pulse ack in RESP.
    task automatic do_txn(input string nm, input logic we, input logic [AW-1:0] addr,
                          input logic [BW-1:0] wdata, input int ack_delay,
                          input logic [BW-1:0] rdata, input int hold, input bit stray);
        rsp_t e;
        int   cnt;
        int   exp_cnt;
        bit   tmo;
        tmo     = (ack_delay < 0) || (ack_delay >= TO);
        exp_cnt = tmo ? TO : ack_delay + 1;
        e.err   = tmo;
        e.data  = (we || tmo) ? '0 : rdata;
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_data_i = wdata;
        n_cmp++;
        if (req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL %s req_ready: got %b want 1", nm, req_ready_o);
        end
        tick();
        req_valid_i = 1'b0; req_addr_i = '1; req_data_i = '1; req_we_i = ~we;
        exp_q.push_back(e);
        cnt = 0;
        while (core_cyc_o === 1'b1 && cnt < 50) begin
            n_cmp++;
            if (core_stb_o !== 1'b1 || core_we_o !== we || core_addr_o !== addr ||
                core_data_o !== wdata || req_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s bus_hold: got stb=%b we=%b addr=%h data=%h want 1 %b %h %h",
                         nm, core_stb_o, core_we_o, core_addr_o, core_data_o, we, addr, wdata);
            end
            cnt++;
            if (ack_delay >= 0 && cnt == ack_delay + 1) begin
                core_ack_i = 1'b1; core_data_i = rdata;
            end
            tick();
            core_ack_i = 1'b0; core_data_i = 32'hBAD0_BAD0;
        end
        n_cmp++;
        if (cnt !== exp_cnt) begin
            n_fail++; $display("FAIL %s bus_cycles: got %0d want %0d", nm, cnt, exp_cnt);
        end
        n_cmp++;
        if (rsp_valid_o !== 1'b1 || core_stb_o !== 1'b0) begin
            n_fail++; $display("FAIL %s rsp_valid: got %b stb=%b want 1 0", nm, rsp_valid_o, core_stb_o);
        end
        for (int i = 0; i < hold; i++) begin
            req_valid_i = 1'b1; req_addr_i = 32'hFFFF_0000;
            if (stray) core_ack_i = 1'b1;
            tick();
            core_ack_i = 1'b0;
            n_cmp++;
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== exp_q[0].data || rsp_err_o !== exp_q[0].err ||
                req_ready_o !== 1'b0 || core_cyc_o !== 1'b0 || core_addr_o !== addr) begin
                n_fail++;
                $display("FAIL %s backpressure: got v=%b d=%h e=%b rdy=%b cyc=%b a=%h want 1 %h %b 0 0 %h",
                         nm, rsp_valid_o, rsp_data_o, rsp_err_o, req_ready_o, core_cyc_o, core_addr_o,
                         exp_q[0].data, exp_q[0].err, addr);
            end
        end
        req_valid_i = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (rsp_data_o !== e.data || rsp_err_o !== e.err) begin
            n_fail++;
            $display("FAIL %s rsp: got data=%h err=%b want data=%h err=%b", nm, rsp_data_o, rsp_err_o, e.data, e.err);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        n_cmp++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_data_o !== e.data || rsp_err_o !== e.err) begin
            n_fail++;
            $display("FAIL %s after_hs: got v=%b rdy=%b d=%h e=%b want 0 1 %h %b",
                     nm, rsp_valid_o, req_ready_o, rsp_data_o, rsp_err_o, e.data, e.err);
        end
    endtask

    task automatic check_idle(input string nm);
        n_cmp++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || core_cyc_o !== 1'b0 || core_stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: got rdy=%b v=%b cyc=%b stb=%b want 1 0 0 0",
                     nm, req_ready_o, rsp_valid_o, core_cyc_o, core_stb_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_data_i = '0;
        rsp_ready_i = 0; core_ack_i = 0; core_data_i = '0;
        #3;
        n_cmp++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 0 || rsp_data_o !== '0 || rsp_err_o !== 0 ||
            core_cyc_o !== 0 || core_stb_o !== 0 || core_we_o !== 0 || core_addr_o !== '0 || core_data_o !== '0) begin
            n_fail++; $display("FAIL reset_state: some output nonzero or req_ready=%b (want 1)", req_ready_o);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        do_txn("write", 1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_read_wait();
        do_txn("read_wait", 1'b0, 32'h20, 32'h0, 3, 32'h12345678, 0, 1'b0);
    endtask

    task automatic test_timeout();
        do_txn("timeout", 1'b0, 32'h30, 32'h0, -1, 32'h0, 0, 1'b0);
        do_txn("ack_last", 1'b0, 32'h34, 32'h0, TO - 1, 32'hCAFE_F00D, 0, 1'b0);
        do_txn("wr_timeout", 1'b1, 32'h38, 32'h5555_AAAA, -1, 32'h0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_txn("bp", 1'b0, 32'h40, 32'h0, 1, 32'hA5A5_0001, 5, 1'b0);
        do_txn("bp_next", 1'b1, 32'h44, 32'h0102_0304, 0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h50; req_data_i = 32'h77;
        tick();
        req_valid_i = 1'b0;
        n_cmp++;
        if (core_cyc_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid in_bus: got cyc=%b want 1", core_cyc_o);
        end
        #2 rst_n = 1'b0;
        #1;
        check_idle("rst_mid");
        tick();
        #2 rst_n = 1'b1;
        tick();
        do_txn("after_rst", 1'b0, 32'h4, 32'h0, 0, 32'h0BAD_CAFE, 0, 1'b0);
    endtask

    task automatic test_stray_ack();
        core_ack_i = 1'b1; core_data_i = 32'h1111_2222;
        tick(); tick();
        core_ack_i = 1'b0;
        check_idle("stray_idle");
        do_txn("stray_resp", 1'b0, 32'h60, 32'h0, 2, 32'h3333_4444, 3, 1'b1);
        check_idle("stray_end");
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_write();
                test_read_wait();
                test_timeout();
                test_backpressure();
                test_reset_mid();
                test_stray_ack();
            end
            begin
                #200000;
                n_fail++;
                $display("FAIL watchdog: got timeout want completion");
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/core_bus_master.md
Name: core_bus_master

Overview:
- Bus initiator for the controller's standard (non-AXI) core bus: drives cyc/stb/we/addr/data and waits for ack.
- A simple request/response port accepts single read or write transactions, runs one bus cycle per request and returns read data plus an error flag.
- Used as the core-side driver for memory access through the Controller, and as a bench/DMA helper. Includes an ack-timeout watchdog so a hung responder cannot lock the requester.

Parameters:
- BUS_WIDTH, 32, data width of the bus and of the request/response ports.
- ADDR_WIDTH, 32, address width.
- TIMEOUT_CYCLES, 255, maximum cycles a bus cycle may stay in BUS without ack; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  transaction address.
- req_data_i  in  BUS_WIDTH  write data.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_data_o  out  BUS_WIDTH  read data; 0 for writes and for errors.
- rsp_err_o  out  1  transaction timed out.
- core_cyc_o  out  1  bus cycle active.
- core_stb_o  out  1  strobe.
- core_we_o  out  1  write enable.
- core_addr_o  out  ADDR_WIDTH  bus address.
- core_data_o  out  BUS_WIDTH  bus write data.
- core_data_i  in  BUS_WIDTH  bus read data.
- core_ack_i  in  1  responder acknowledge.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Enter IDLE.
  - All outputs 0 except req_ready_o=1.
  - Timeout counter cleared.
  - Takes effect immediately, including mid-BUS: cyc/stb drop without waiting for ack.
  - A pending response is discarded.
- Handshake rule: a transfer occurs on a rising edge where valid=1 and ready=1.
- FSM states: IDLE, BUS, RESP. req_ready_o is 1 only in IDLE (registered state decode, no combinational path from req_valid_i).
- IDLE:
  - On request accept at edge N, latch we/addr/data into core_we_o/core_addr_o/core_data_o, clear the counter and go to BUS.
  - cyc=stb=1 from cycle N+1.
- BUS:
  - cyc, stb, we, addr and data are held stable.
  - Counter increments every cycle core_ack_i=0.
- Ack sampled at edge M:
  - Read: rsp_data_o<=core_data_i.
  - Write: rsp_data_o<=0.
  - rsp_err_o<=0, cyc=stb=0 and rsp_valid_o=1 from cycle M+1; go to RESP.
  - Minimum bus occupancy is 1 cycle (zero-wait responder).
- Timeout:
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 with no ack, the next edge drops cyc/stb, sets rsp_err_o=1 and rsp_data_o=0, and goes to RESP.
  - Ack on that same edge wins: normal completion, err=0.
  - Counter width is $clog2(TIMEOUT_CYCLES+1). With TIMEOUT_CYCLES=0 the counter is held and the block waits indefinitely.
- RESP:
  - rsp_valid_o/rsp_data_o/rsp_err_o are held until rsp_ready_i=1 at edge K.
  - From cycle K+1: rsp_valid_o=0, state IDLE, req_ready_o=1.
  - rsp_data_o and rsp_err_o retain their last value after the handshake.
- core_ack_i outside BUS is ignored: no state change, no response.
- Throughput: at most one transaction outstanding. Back-to-back with zero-wait ack and rsp_ready_i tied high is 3 cycles per transaction (IDLE, BUS, RESP).
- core_we_o/addr/data keep their last value when cyc=0; only cyc/stb qualify the bus.

Test Plan:
- Write: req we=1 addr=0x00000010 data=0xDEADBEEF, ack the first BUS cycle -> cyc/stb high exactly 1 cycle with that addr/data; rsp_valid=1 next cycle with rsp_data=0, rsp_err=0.
- Read with wait states: req we=0 addr=0x00000020, responder acks after 3 cycles with core_data_i=0x12345678 -> stb high 4 cycles; rsp_data=0x12345678, rsp_err=0.
- Timeout: TIMEOUT_CYCLES=8, never ack -> cyc drops after exactly 8 BUS cycles; rsp_err=1, rsp_data=0. Repeat with ack on the 8th cycle -> err=0, normal data.
- Backpressure: hold rsp_ready_i=0 for 5 cycles -> rsp_valid and data held stable, req_ready=0, new req_valid ignored. Raise rsp_ready -> req_ready=1 next cycle; the following request completes normally.
- Reset mid-transaction: pull rst_n low during BUS -> cyc/stb/rsp_valid go 0 and req_ray=1 immediately (asynchronous). After release, a read to 0x4 completes normally.
- Stray ack: pulse core_ack_i in IDLE and RESP -> no response generated, no state change.
